bcd_display_mux: RTL and testbench

- Downstream display stage for the die-roll counter.
- Consumes the two BCD digits (tens, units) that the counter drives on its dedicated outputs.
- Drives a 2-digit, time-multiplexed, common-cathode 7-segment display.
- Provides leading-zero blanking, 3-bit brightness PWM, an anti-ghosting dead cycle, and frame-synchronous capture of the displayed value, so a digit never changes mid-frame.

---
 rtl/bcd_display_mux_if.sv | 13 +
 rtl/bcd_display_mux.sv | 67 ++++++
 tb/tb_bcd_display_mux.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bcd_display_mux_if.sv
// bcd_display_mux_if: BCD digit inputs and multiplexed 7-segment outputs of the display stage
interface bcd_display_mux_if;
  logic       ena;
  logic [3:0] digit10;
  logic [3:0] digit1;
  logic       blank_lz;
  logic [2:0] bright;
  logic [6:0] seg;
  logic [1:0] dig;
  logic       frame;
  modport master(output ena, digit10, digit1, blank_lz, bright, input seg, dig, frame);
  modport slave(input ena, digit10, digit1, blank_lz, bright, output seg, dig, frame);
endinterface

// File: rtl/bcd_display_mux.sv
// bcd_display_mux: 2-digit multiplexed 7-segment driver with frame-synchronous capture and PWM
module bcd_display_mux #(
  parameter int DIV_LOG2    = 6,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  bcd_display_mux_if.slave  bus
);
  logic [DIV_LOG2-1:0] cnt;
  logic                sel;
  logic [3:0]          sh10;
  logic [3:0]          sh1;
  logic [6:0]          seg_q;
  logic [1:0]          dig_q;
  logic                frame_q;
  logic                wrap;
  logic                cap;
  logic                on;
  logic [3:0]          cur;
  logic [6:0]          dec;
  assign wrap = &cnt;
  assign cap  = bus.ena & wrap & sel;
  assign cur  = sel ? sh1 : sh10;
  // cnt == 0 is the anti-ghosting dead cycle; the top three cnt bits give the PWM phase
  assign on   = bus.ena && cnt != '0 && cnt[DIV_LOG2-1 -: 3] <= bus.bright &&
                (sel || !(bus.blank_lz && sh10 == 4'd0));
  always_comb
    case (cur)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h40;
    endcase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= '0;
      sel     <= 1'b0;
      sh10    <= 4'd0;
      sh1     <= 4'd0;
      seg_q   <= 7'h00;
      dig_q   <= 2'b00;
      frame_q <= 1'b0;
    end else begin
      if (bus.ena) begin
        cnt <= cnt + 1'b1;
        if (wrap) sel <= ~sel;
      end
      if (cap) begin
        sh10 <= bus.digit10;
        sh1  <= bus.digit1;
      end
      frame_q <= cap;
      seg_q   <= on ? dec : 7'h00;
      dig_q   <= on ? {~sel, sel} : 2'b00;
    end
  assign bus.seg   = seg_q ^ {7{SEG_ACT_LOW}};
  assign bus.dig   = dig_q ^ {2{SEG_ACT_LOW}};
  assign bus.frame = frame_q;
endmodule

// File: tb/tb_bcd_display_mux.sv
// tb_bcd_display_mux: directed scenario bench for the 2-digit display multiplexer
module tb_bcd_display_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bcd_display_mux_if bus();
  bcd_display_mux dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.frame && n < 400);
  endtask
  task automatic run_frame(input logic [6:0] s10, input logic [6:0] s1, output int n10, output int n1, output int bad);
    n10 = 0;
    n1  = 0;
    bad = 0;
    for (int m = 1; m <= 128; m++) begin
      tick();
      if (bus.dig === 2'b10) begin
        n10++;
        if (bus.seg !== s10) bad++;
      end else if (bus.dig === 2'b01) begin
        n1++;
        if (bus.seg !== s1) bad++;
      end else if (bus.dig !== 2'b00 || bus.seg !== 7'h00) bad++;
      if (bus.frame !== (m == 128)) bad++;
    end
  endtask
  task automatic test_reset;
    int n;
    bus.ena = 1'b1; bus.digit10 = 4'd3; bus.digit1 = 4'd3; bus.blank_lz = 1'b0; bus.bright = 3'd7;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.seg !== 7'h00) begin errors++; $display("FAIL reset_seg got=%h exp=00", bus.seg); end
    checks++; if (bus.dig !== 2'b00) begin errors++; $display("FAIL reset_dig got=%b exp=00", bus.dig); end
    checks++; if (bus.frame !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b exp=0", bus.frame); end
    rst_n = 1'b1;
    wait_frame(n);
    checks++; if (n !== 128) begin errors++; $display("FAIL first_frame got=%0d exp=128", n); end
    repeat (10) tick();
    checks++; if (bus.dig !== 2'b10 || bus.seg !== 7'h4F) begin errors++; $display("FAIL pre_reset got=%b/%h exp=10/4f", bus.dig, bus.seg); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.dig !== 2'b00 || bus.seg !== 7'h00 || bus.frame !== 1'b0) begin
      errors++; $display("FAIL async_reset got=%b/%h/%b exp=00/00/0", bus.dig, bus.seg, bus.frame); end
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (bus.dig !== 2'b10 || bus.seg !== 7'h3F) begin errors++; $display("FAIL post_reset_zero got=%b/%h exp=10/3f", bus.dig, bus.seg); end
  endtask
  task automatic test_digits;
    int n, n10, n1, bad;
    bus.digit10 = 4'd2; bus.digit1 = 4'd0; bus.bright = 3'd7; bus.blank_lz = 1'b1;
    wait_frame(n);
    checks++; if (n > 128) begin errors++; $display("FAIL digits_sync got=%0d exp<=128", n); end
    run_frame(7'h5B, 7'h3F, n10, n1, bad);
    checks++; if (n10 !== 63) begin errors++; $display("FAIL digits_tens_cnt got=%0d exp=63", n10); end
    checks++; if (n1 !== 63) begin errors++; $display("FAIL digits_units_cnt got=%0d exp=63", n1); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL digits_pattern got=%0d bad exp=0", bad); end
  endtask
  task automatic test_blanking;
    int n, n10, n1, bad;
    bus.digit10 = 4'd0; bus.digit1 = 4'd4; bus.blank_lz = 1'b1;
    wait_frame(n);
    run_frame(7'h3F, 7'h66, n10, n1, bad);
    checks++; if (n10 !== 0) begin errors++; $display("FAIL blank_tens_cnt got=%0d exp=0", n10); end
    checks++; if (n1 !== 63 || bad !== 0) begin errors++; $display("FAIL blank_units got=%0d/%0d exp=63/0", n1, bad); end
    repeat (10) tick();
    checks++; if (bus.dig !== 2'b00) begin errors++; $display("FAIL blank_mid got=%b exp=00", bus.dig); end
    bus.blank_lz = 1'b0;
    tick();
    checks++; if (bus.dig !== 2'b10 || bus.seg !== 7'h3F) begin errors++; $display("FAIL unblank got=%b/%h exp=10/3f", bus.dig, bus.seg); end
  endtask
  task automatic test_capture;
    int n, n10, n1, bad;
    bus.digit10 = 4'd1; bus.digit1 = 4'd6;
    wait_frame(n);
    n1 = 0; bad = 0;
    for (int m = 1; m <= 128; m++) begin
      tick();
      if (m == 20) bus.digit1 = 4'd5;
      if (bus.dig === 2'b01) begin
        n1++;
        if (bus.seg !== 7'h7D) bad++;
      end
    end
    checks++; if (n1 !== 63 || bad !== 0) begin errors++; $display("FAIL capture_hold got=%0d/%0d exp=63/0", n1, bad); end
    checks++; if (bus.frame !== 1'b1) begin errors++; $display("FAIL capture_frame got=%b exp=1", bus.frame); end
    run_frame(7'h06, 7'h6D, n10, n1, bad);
    checks++; if (n10 !== 63 || n1 !== 63 || bad !== 0) begin errors++; $display("FAIL capture_new got=%0d/%0d/%0d exp=63/63/0", n10, n1, bad); end
  endtask
  task automatic test_brightness;
    int n10, n1, bad;
    logic [2:0] lv [3] = '{3'd0, 3'd3, 3'd7};
    int         ex [3] = '{7, 31, 63};
    bus.digit10 = 4'd8; bus.digit1 = 4'd9;
    run_frame(7'h06, 7'h6D, n10, n1, bad);
    for (int i = 0; i < 3; i++) begin
      bus.bright = lv[i];
      run_frame(7'h7F, 7'h6F, n10, n1, bad);
      checks++; if (n10 !== ex[i] || n1 !== ex[i] || bad !== 0) begin
        errors++; $display("FAIL bright_%0d got=%0d/%0d/%0d exp=%0d/%0d/0", lv[i], n10, n1, bad, ex[i], ex[i]); end
    end
  endtask
  task automatic test_ena;
    int n, n1, bad;
    bus.digit10 = 4'd1; bus.digit1 = 4'hC;
    wait_frame(n);
    repeat (70) tick();
    checks++; if (bus.dig !== 2'b01 || bus.seg !== 7'h40) begin errors++; $display("FAIL dash got=%b/%h exp=01/40", bus.dig, bus.seg); end
    bus.ena = 1'b0;
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.dig !== 2'b00 || bus.seg !== 7'h00 || bus.frame !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ena_dark got=%0d bad exp=0", bad); end
    bus.ena = 1'b1;
    n = 0; n1 = 0;
    do begin
      tick();
      n++;
      if (bus.dig === 2'b01 && bus.seg === 7'h40) n1++;
    end while (!bus.frame && n < 200);
    checks++; if (n !== 58) begin errors++; $display("FAIL ena_resume_frame got=%0d exp=58", n); end
    checks++; if (n1 !== 58) begin errors++; $display("FAIL ena_resume_lit got=%0d exp=58", n1); end
  endtask
  initial begin
    test_reset();
    test_digits();
    test_blanking();
    test_capture();
    test_brightness();
    test_ena();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
